// File: rtl/if_prefetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// if_pkg: shared types and constants for the instruction-fetch front end.
//   IF_XLEN        native instruction/PC width of a queued fetch entry
//   NOP_INST       value driven on d_inst when no instruction is presented
//   fetch_entry_t  {pc, inst} pair carried through the prefetch queue
//   align_pc()     forces a target PC to a word boundary
// -----------------------------------------------------------------------------
package if_pkg;

  localparam int IF_XLEN = 32;

  localparam logic [IF_XLEN-1:0] NOP_INST = 32'h0;

  typedef struct packed {
    logic [IF_XLEN-1:0] pc;
    logic [IF_XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [IF_XLEN-1:0] align_pc(input logic [IF_XLEN-1:0] pc);
    return {pc[IF_XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_prefetch_queue_if.sv
// -----------------------------------------------------------------------------
// if_prefetch_queue_if: bundle of the fetch unit's IM bus, E-stage redirect
// and decode-side handshake.
//   master : fetch unit (drives im_cs/im_addr and d_valid/d_inst/d_pc/occupancy)
//   slave  : environment (IM SRAM, E stage, decode stage)
//   im_cs/im_addr/im_rdata      instruction SRAM request and 1-cycle-late data
//   redirect/redirect_pc        taken jump/branch and its target
//   d_stall                     decode cannot accept this cycle
//   d_valid/d_inst/d_pc         instruction presented to decode
//   occupancy                   queue entry count (bypass not included)
// -----------------------------------------------------------------------------
interface if_prefetch_queue_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 4
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic              im_cs;
  logic [ADDR_W-1:0] im_addr;
  logic [XLEN-1:0]   im_rdata;
  logic              redirect;
  logic [XLEN-1:0]   redirect_pc;
  logic              d_stall;
  logic              d_valid;
  logic [XLEN-1:0]   d_inst;
  logic [XLEN-1:0]   d_pc;
  logic [OCC_W-1:0]  occupancy;

  modport master (
    output im_cs, im_addr, d_valid, d_inst, d_pc, occupancy,
    input  im_rdata, redirect, redirect_pc, d_stall
  );

  modport slave (
    input  im_cs, im_addr, d_valid, d_inst, d_pc, occupancy,
    output im_rdata, redirect, redirect_pc, d_stall
  );

endinterface

// File: rtl/if_prefetch_queue_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo: DEPTH-entry circular buffer with head/tail pointers and count.
//   clk, rst  clock, asynchronous active-high reset (pointers/count only)
//   push/din  write din at the tail
//   pop/dout  dout is the head entry; pop advances the head
//   flush     empties the buffer, overriding push and pop
//   count     number of valid entries; empty/full derived from it
// Simultaneous push and pop is allowed at any fill level, including full.
// -----------------------------------------------------------------------------
module fetch_fifo
  import if_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_entry_t
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  T                             din,
  output T                             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == OCC_W'(DEPTH));
  assign dout    = mem[head];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + PTR_W'(1);
      if (do_pop)  head <= head + PTR_W'(1);
      count <= count + OCC_W'(do_push) - OCC_W'(do_pop);
    end
  end

  // Storage carries data only and is never reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[tail] <= din;
  end

  always @(posedge clk) begin
    if (!rst && !flush) begin
      assert (!(push && full && !pop)) else $error("fetch_fifo: push while full");
    end
  end

endmodule

// File: rtl/if_prefetch_queue.sv
// -----------------------------------------------------------------------------
// if_prefetch_queue: instruction-fetch front end. Holds the fetch PC, issues
// IM reads, tracks the single in-flight read and buffers responses in a
// DEPTH-entry queue so decode stalls never cause an IM re-read.
//   clk  clock
//   rst  asynchronous active-high reset
//   bus  if_prefetch_queue_if.master (IM bus, redirect, decode handshake)
// Parameters: XLEN, DEPTH (power of 2, >=2), ADDR_W (IM word address),
// RESET_PC (word-aligned fetch PC after reset).
// -----------------------------------------------------------------------------
module if_prefetch_queue
  import if_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter int              ADDR_W   = 14,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  if_prefetch_queue_if.master bus
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PC_W  = ADDR_W + 2;

  if (XLEN != IF_XLEN) begin : g_xlen_check
    $error("if_prefetch_queue: XLEN must match if_pkg::IF_XLEN");
  end

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  issue_pc;
  logic [XLEN-1:0]  fetch_pc_nxt;
  logic [XLEN-1:0]  req_pc_p1;
  logic             inflight_p1;
  logic             kill_p1;
  logic             resp_vld_p1;
  fetch_entry_t     resp_p1;
  fetch_entry_t     q_head;
  logic [OCC_W-1:0] q_count;
  logic             q_empty;
  logic             q_full;
  logic             q_push;
  logic             q_pop;

  // ---- p0: request generation ----
  assign issue_pc = bus.redirect ? align_pc(bus.redirect_pc) : fetch_pc;

  // The credit check ignores a same-cycle pop, so every issued read is
  // guaranteed a queue slot when its data returns.
  assign bus.im_cs   = !rst && (bus.redirect || ((int'(q_count) + int'(inflight_p1)) < DEPTH));
  assign bus.im_addr = issue_pc[ADDR_W+1:2];

  // Sequential fetch wraps within the IM address space.
  always_comb begin
    fetch_pc_nxt            = '0;
    fetch_pc_nxt[PC_W-1:0]  = issue_pc[PC_W-1:0] + PC_W'(4);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight_p1 <= 1'b0;
      kill_p1     <= 1'b0;
    end else begin
      inflight_p1 <= bus.im_cs;
      // The stale response of a pre-redirect read lands in the redirect cycle
      // itself and is masked there; kill only has to cover a redirect cycle in
      // which no replacement read went out.
      kill_p1     <= bus.redirect && inflight_p1 && !bus.im_cs;
      if (bus.im_cs) fetch_pc <= fetch_pc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.im_cs) req_pc_p1 <= issue_pc;
  end

  // ---- p1: response, bypass and queue ----
  assign resp_vld_p1  = inflight_p1 && !kill_p1;
  assign resp_p1.pc   = req_pc_p1;
  assign resp_p1.inst = bus.im_rdata;

  always_comb begin
    bus.d_valid = 1'b0;
    bus.d_inst  = NOP_INST;
    bus.d_pc    = '0;
    if (!bus.redirect) begin
      if (!q_empty) begin
        bus.d_valid = 1'b1;
        bus.d_inst  = q_head.inst;
        bus.d_pc    = q_head.pc;
      end else if (resp_vld_p1) begin
        bus.d_valid = 1'b1;
        bus.d_inst  = resp_p1.inst;
        bus.d_pc    = resp_p1.pc;
      end
    end
  end

  // With an empty queue the response goes straight to decode and is only
  // queued if decode stalls; otherwise it always joins the tail.
  assign q_push = resp_vld_p1 && !bus.redirect && (!q_empty || bus.d_stall);
  assign q_pop  = bus.d_valid && !bus.d_stall && !q_empty;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch_entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .flush (bus.redirect),
    .din   (resp_p1),
    .dout  (q_head),
    .count (q_count),
    .empty (q_empty),
    .full  (q_full)
  );

  assign bus.occupancy = q_count;

endmodule
